p20_vga_timing: RTL and testbench
=================================

Name: p20_vga_timing

Overview:
Free-running VGA raster timing generator inside p20_dinogame. It produces pixel coordinates, blanking and per-frame/per-line event pulses for the sprite and obstacle logic, plus sync outputs that drive vga_hsync/vga_vsync. The sync and active outputs are delayed by a programmable number of cycles so they stay aligned with the registered pixel pipeline that drives vga_pixel. The default configuration is 640x480@60 (25.175 MHz nominal pixel clock, one pixel per clk).

Parameters:
H_ACTIVE, 640, visible pixels per line
H_FP, 16, horizontal front porch (clks)
H_SYNC, 96, horizontal sync width (clks)
H_BP, 48, horizontal back porch (clks)
V_ACTIVE, 480, visible lines per frame
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vertical sync width (lines)
V_BP, 33, vertical back porch (lines)
H_POL, 0, hsync asserted level (0 = active-low)
V_POL, 0, vsync asserted level
SYNC_DELAY, 2, pipeline depth applied to hsync/vsync/active_d (0..7)

Ports:
clk  in  1  pixel clock
sys_rst  in  1  synchronous active-high reset
hpos  out  10  current column, 0..H_TOTAL-1 (H_TOTAL = sum of H_* = 800)
vpos  out  10  current line, 0..V_TOTAL-1 (V_TOTAL = 525)
active  out  1  hpos<H_ACTIVE && vpos<V_ACTIVE, undelayed
line_start  out  1  one-clk pulse when hpos==0
frame_start  out  1  one-clk pulse when hpos==0 && vpos==0
vblank_start  out  1  one-clk pulse when hpos==0 && vpos==V_ACTIVE (game-state update strobe)
active_d  out  1  active delayed by SYNC_DELAY
hsync  out  1  delayed horizontal sync at H_POL polarity
vsync  out  1  delayed vertical sync at V_POL polarity

Behaviour:
- Only clk is used; all flops update on its rising edge. Reset is synchronous, active-high: sys_rst sampled high on a rising clk edge resets state that same edge.
- Reset values: hpos=0, vpos=0. Every delay-pipe stage is loaded with the inactive level: active_d=0, hsync=!H_POL, vsync=!V_POL.
- Pulses (line_start, frame_start, vblank_start) and active are combinational decodes of hpos/vpos. They therefore read 1 for line_start/frame_start/active in the cycle immediately after reset releases.
- Counter: hpos increments every clk. When hpos==H_TOTAL-1, hpos wraps to 0 and vpos increments. When vpos==V_TOTAL-1 as well, vpos wraps to 0.
- No counter stalls or enables exist; the raster never stops (the halt input affects game logic only).
- Raw hsync asserted iff H_ACTIVE+H_FP <= hpos < H_ACTIVE+H_FP+H_SYNC (656..751 by default).
- Raw vsync asserted iff V_ACTIVE+V_FP <= vpos < V_ACTIVE+V_FP+V_SYNC (490..491). Raw vsync changes on the hpos=0 boundary; it is not offset mid-line.
- Delay: outputs hsync/vsync/active_d equal the raw values from SYNC_DELAY clocks earlier, through a shift register of SYNC_DELAY stages. With SYNC_DELAY=0 they are combinational from the counters.
- Consumer contract: the pixel generator samples hpos/vpos in cycle t and presents the pixel in cycle t+SYNC_DELAY. Pixel output must be gated by active_d.
- Width: 10-bit counters. Elaboration must fail (assertion) if H_TOTAL>1024, V_TOTAL>1024 or SYNC_DELAY>7.
- Reset mid-frame: counters return to 0 on the next edge and pipe stages go inactive. The first line_start/frame_start pulse appears in the first cycle after sys_rst deasserts. No partial-frame sync glitch is emitted beyond the delay pipe draining its inactive values.
- Period: exactly H_TOTAL*V_TOTAL = 420000 clks between frame_start pulses, and H_TOTAL = 800 clks between line_start pulses.

Test Plan:
- Reset then release -> cycle 0: hpos=0, vpos=0, frame_start=1, line_start=1, active=1. With SYNC_DELAY=2, active_d=0 and hsync=1 for the first 2 clks, then active_d=1.
- Run one line -> active falls at hpos=640. Raw hsync goes low at hpos=656 and high at hpos=752; the output hsync edges appear 2 clks later. Width is 96 clks low.
- Run 2 frames -> frame_start pulses exactly 420000 clks apart. vblank_start fires once per frame at vpos=480, hpos=0. vsync is low for exactly 1600 clks (2 lines) starting at the first clk of line 490 plus 2.
- Line wrap check -> at hpos=799, vpos=524 the next clk gives hpos=0, vpos=0 and frame_start=1. vpos never reads 525 and hpos never reads 800.
- Assert sys_rst for 3 clks at hpos=700, vpos=491 (hsync/vsync asserted) -> outputs go inactive (1/1) within 1 clk of reset. hpos/vpos=0 immediately after release. Next hsync assertion occurs 656+2 clks after release.
- Re-elaborate with SYNC_DELAY=0, H_POL=1, V_POL=1 -> hsync is high, combinationally, exactly when hpos is in 656..751. active_d==active every cycle. Scoreboard compares against a reference raster model for one frame.

Source files
------------

// File: rtl/p20_vga_timing.sv
// p20_vga_timing: free-running VGA raster counter with event pulses and
// sync/active outputs delayed to line up with the registered pixel path.
// Ports: clk, sys_rst (sync, active-high) in; hpos[9:0], vpos[9:0], active,
//   line_start, frame_start, vblank_start (undelayed decodes) out;
//   active_d, hsync, vsync (delayed by SYNC_DELAY clks) out.
module p20_vga_timing #(
    parameter int unsigned H_ACTIVE   = 640,
    parameter int unsigned H_FP       = 16,
    parameter int unsigned H_SYNC     = 96,
    parameter int unsigned H_BP       = 48,
    parameter int unsigned V_ACTIVE   = 480,
    parameter int unsigned V_FP       = 10,
    parameter int unsigned V_SYNC     = 2,
    parameter int unsigned V_BP       = 33,
    parameter bit          H_POL      = 1'b0,
    parameter bit          V_POL      = 1'b0,
    parameter int unsigned SYNC_DELAY = 2
) (
    input  logic       clk,
    input  logic       sys_rst,
    output logic [9:0] hpos,
    output logic [9:0] vpos,
    output logic       active,
    output logic       line_start,
    output logic       frame_start,
    output logic       vblank_start,
    output logic       active_d,
    output logic       hsync,
    output logic       vsync
);

    localparam int unsigned H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int unsigned HS_START = H_ACTIVE + H_FP;
    localparam int unsigned HS_END   = HS_START + H_SYNC;
    localparam int unsigned VS_START = V_ACTIVE + V_FP;
    localparam int unsigned VS_END   = VS_START + V_SYNC;

    localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);

    // Pipe order is {active, hsync, vsync}; idle is deasserted on all three.
    localparam logic [2:0] IDLE = {1'b0, ~H_POL, ~V_POL};

    if (H_TOTAL > 1024) begin : g_err_h
        $error("p20_vga_timing: H_TOTAL exceeds 10-bit counter");
    end
    if (V_TOTAL > 1024) begin : g_err_v
        $error("p20_vga_timing: V_TOTAL exceeds 10-bit counter");
    end
    if (SYNC_DELAY > 7) begin : g_err_d
        $error("p20_vga_timing: SYNC_DELAY above 7");
    end

    logic [31:0] hp;
    logic [31:0] vp;
    logic        hs_on;
    logic        vs_on;
    logic [2:0]  raw;

    assign hp = {22'd0, hpos};
    assign vp = {22'd0, vpos};

    always_ff @(posedge clk) begin
        if (sys_rst) begin
            hpos <= '0;
            vpos <= '0;
        end else if (hpos == H_LAST) begin
            hpos <= '0;
            if (vpos == V_LAST) begin
                vpos <= '0;
            end else begin
                vpos <= vpos + 10'd1;
            end
        end else begin
            hpos <= hpos + 10'd1;
        end
    end

    assign active       = (hp < H_ACTIVE) && (vp < V_ACTIVE);
    assign line_start   = (hpos == 10'd0);
    assign frame_start  = line_start && (vpos == 10'd0);
    assign vblank_start = line_start && (vp == V_ACTIVE);

    // vsync is decoded from vpos only, so it switches at hpos 0.
    assign hs_on = (hp >= HS_START) && (hp < HS_END);
    assign vs_on = (vp >= VS_START) && (vp < VS_END);

    assign raw = {active,
                  hs_on ? H_POL : ~H_POL,
                  vs_on ? V_POL : ~V_POL};

    if (SYNC_DELAY == 0) begin : g_nodly
        assign {active_d, hsync, vsync} = raw;
    end else begin : g_dly
        logic [2:0] pipe [SYNC_DELAY];

        always_ff @(posedge clk) begin
            if (sys_rst) begin
                for (int i = 0; i < int'(SYNC_DELAY); i++) begin
                    pipe[i] <= IDLE;
                end
            end else begin
                pipe[0] <= raw;
                for (int i = 1; i < int'(SYNC_DELAY); i++) begin
                    pipe[i] <= pipe[i-1];
                end
            end
        end

        assign {active_d, hsync, vsync} = pipe[SYNC_DELAY-1];
    end

endmodule

// File: tb/tb_p20_vga_timing.sv
// tb_p20_vga_timing: directed vectors and sequences for p20_vga_timing.
// Three instances: default 640x480, short-frame, and zero-delay/active-high.
module tb_p20_vga_timing;

    logic clk;
    logic sys_rst;

    // default configuration
    logic [9:0] h_a, v_a;
    logic act_a, ls_a, fs_a, vbs_a, ad_a, hs_a, vs_a;
    // default horizontal, short vertical (V_TOTAL = 10)
    logic [9:0] h_v, v_v;
    logic act_v, ls_v, fs_v, vbs_v, ad_v, hs_v, vs_v;
    // short vertical, SYNC_DELAY = 0, positive sync polarity
    logic [9:0] h_z, v_z;
    logic act_z, ls_z, fs_z, vbs_z, ad_z, hs_z, vs_z;

    p20_vga_timing dut (
        .clk(clk), .sys_rst(sys_rst), .hpos(h_a), .vpos(v_a),
        .active(act_a), .line_start(ls_a), .frame_start(fs_a),
        .vblank_start(vbs_a), .active_d(ad_a), .hsync(hs_a), .vsync(vs_a)
    );

    p20_vga_timing #(
        .V_ACTIVE(4), .V_FP(2), .V_SYNC(2), .V_BP(2)
    ) dut_v (
        .clk(clk), .sys_rst(sys_rst), .hpos(h_v), .vpos(v_v),
        .active(act_v), .line_start(ls_v), .frame_start(fs_v),
        .vblank_start(vbs_v), .active_d(ad_v), .hsync(hs_v), .vsync(vs_v)
    );

    p20_vga_timing #(
        .V_ACTIVE(4), .V_FP(2), .V_SYNC(2), .V_BP(2),
        .H_POL(1'b1), .V_POL(1'b1), .SYNC_DELAY(0)
    ) dut_z (
        .clk(clk), .sys_rst(sys_rst), .hpos(h_z), .vpos(v_z),
        .active(act_z), .line_start(ls_z), .frame_start(fs_z),
        .vblank_start(vbs_z), .active_d(ad_z), .hsync(hs_z), .vsync(vs_z)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;

    // reference raster for dut_z
    int mh = 0;
    int mv = 0;
    int z_prints = 0;

    // monitors on the first two frames
    bit mon_en = 1'b0;
    int last_ls = -1;
    int fs_t[$];
    int vbs_cnt = 0;
    int vs_start = -1;
    int vs_end = -1;
    int max_h = 0;
    int max_v = 0;

    typedef struct {
        int k;
        int h;
        int v;
        bit act;
        bit ls;
        bit fs;
        bit hs;
        bit ad;
    } vec_t;

    vec_t vecs[14];

    task automatic check(input string name, input int idx,
                         input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s[%0d]: got %0h expected %0h", name, idx, got, exp);
        end
    endtask

    task automatic tick();
        logic rst_edge;
        logic [25:0] got_z;
        logic [25:0] exp_z;
        bit e_act;
        rst_edge = sys_rst;
        @(posedge clk);
        #1;
        cyc++;
        if (rst_edge) begin
            mh = 0;
            mv = 0;
        end else if (mh == 799) begin
            mh = 0;
            mv = (mv == 9) ? 0 : mv + 1;
        end else begin
            mh++;
        end
        e_act = (mh < 640) && (mv < 4);
        exp_z = {10'(mh), 10'(mv), e_act, e_act,
                 mh == 0, mh == 0 && mv == 0, mh == 0 && mv == 4,
                 mh >= 656 && mh < 752};
        got_z = {h_z, v_z, act_z, ad_z, ls_z, fs_z, vbs_z, hs_z};
        n_chk++;
        if (got_z !== exp_z || vs_z !== (mv == 6 || mv == 7)) begin
            n_fail++;
            if (z_prints < 20) begin
                z_prints++;
                $display("FAIL zero_delay[%0d]: got %h/%b expected %h/%b",
                         cyc, got_z, vs_z, exp_z, (mv == 6 || mv == 7));
            end
        end
        if (mon_en) begin
            if (ls_a) begin
                if (last_ls >= 0) check("ls_period", cyc, cyc - last_ls, 800);
                last_ls = cyc;
            end
            if (fs_v) fs_t.push_back(cyc);
            if (vbs_v) begin
                vbs_cnt++;
                check("vbs_pos", cyc, {h_v, v_v}, {10'd0, 10'd4});
            end
            if (!vs_v && vs_start < 0) vs_start = cyc;
            if (vs_v && vs_start >= 0 && vs_end < 0) vs_end = cyc;
            if (int'(h_v) > max_h) max_h = int'(h_v);
            if (int'(v_v) > max_v) max_v = int'(v_v);
        end
    endtask

    task automatic step_to(input int k);
        while (cyc < k) tick();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int first_hs;
        int vs_glitch;

        vecs[0]  = '{0,   0,   0, 1, 1, 1, 1, 0};
        vecs[1]  = '{1,   1,   0, 1, 0, 0, 1, 0};
        vecs[2]  = '{2,   2,   0, 1, 0, 0, 1, 1};
        vecs[3]  = '{639, 639, 0, 1, 0, 0, 1, 1};
        vecs[4]  = '{640, 640, 0, 0, 0, 0, 1, 1};
        vecs[5]  = '{641, 641, 0, 0, 0, 0, 1, 1};
        vecs[6]  = '{642, 642, 0, 0, 0, 0, 1, 0};
        vecs[7]  = '{657, 657, 0, 0, 0, 0, 1, 0};
        vecs[8]  = '{658, 658, 0, 0, 0, 0, 0, 0};
        vecs[9]  = '{753, 753, 0, 0, 0, 0, 0, 0};
        vecs[10] = '{754, 754, 0, 0, 0, 0, 1, 0};
        vecs[11] = '{799, 799, 0, 0, 0, 0, 1, 0};
        vecs[12] = '{800, 0,   1, 1, 1, 0, 1, 0};
        vecs[13] = '{802, 2,   1, 1, 0, 0, 1, 1};

        sys_rst = 1'b1;
        repeat (3) tick();
        check("rst_out", 0, {hs_a, vs_a, ad_a}, 3'b110);
        sys_rst = 1'b0;
        cyc = 0;
        mon_en = 1'b1;

        check("v_start", 0, {h_v, v_v, fs_v, ad_v, hs_v, vs_v},
              {10'd0, 10'd0, 4'b1011});

        for (int i = 0; i < 14; i++) begin
            step_to(vecs[i].k);
            check("vec.hpos", i, 32'(h_a), 32'(vecs[i].h));
            check("vec.vpos", i, 32'(v_a), 32'(vecs[i].v));
            check("vec.active", i, 32'(act_a), 32'(vecs[i].act));
            check("vec.line_start", i, 32'(ls_a), 32'(vecs[i].ls));
            check("vec.frame_start", i, 32'(fs_a), 32'(vecs[i].fs));
            check("vec.hsync", i, 32'(hs_a), 32'(vecs[i].hs));
            check("vec.active_d", i, 32'(ad_a), 32'(vecs[i].ad));
            check("vec.vsync", i, 32'(vs_a), 32'd1);
        end

        step_to(7999);
        check("wrap_before", 0, {h_v, v_v, fs_v}, {10'd799, 10'd9, 1'b0});
        step_to(8000);
        check("wrap_after", 0, {h_v, v_v, fs_v}, {10'd0, 10'd0, 1'b1});

        step_to(16100);
        mon_en = 1'b0;
        check("fs_count", 0, fs_t.size(), 2);
        if (fs_t.size() == 2) begin
            check("fs_first", 0, fs_t[0], 8000);
            check("fs_period", 0, fs_t[1] - fs_t[0], 8000);
        end
        check("vbs_count", 0, vbs_cnt, 2);
        check("vs_start", 0, vs_start, 4802);
        check("vs_width", 0, vs_end - vs_start, 1600);
        check("max_hpos", 0, max_h, 799);
        check("max_vpos", 0, max_v, 9);

        // dut_v sits at line 7, column 700: both syncs asserted
        step_to(22300);
        check("pre_rst_v", 0, {h_v, v_v, hs_v, vs_v},
              {10'd700, 10'd7, 2'b00});
        check("pre_rst_a", 0, {h_a, hs_a}, {10'd700, 1'b0});
        sys_rst = 1'b1;
        tick();
        check("rst_edge_v", 0, {h_v, v_v, ad_v, hs_v, vs_v},
              {10'd0, 10'd0, 3'b011});
        check("rst_edge_a", 0, {h_a, v_a, ad_a, hs_a, vs_a},
              {10'd0, 10'd0, 3'b011});
        tick();
        tick();
        sys_rst = 1'b0;
        cyc = 0;
        check("rel_v", 0, {h_v, v_v, ls_v, fs_v, act_v, hs_v, vs_v},
              {10'd0, 10'd0, 5'b11111});

        first_hs = -1;
        vs_glitch = 0;
        for (int i = 0; i < 4000; i++) begin
            tick();
            if (!hs_v && first_hs < 0) first_hs = cyc;
            if (!vs_v) vs_glitch++;
        end
        check("hs_after_rst", 0, first_hs, 658);
        check("vs_glitch", 0, vs_glitch, 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
